playlist_mcu: RTL and testbench
===============================

# playlist_mcu

Playback control unit for the music player: turns debounced one-cycle button pulses and the note player's song_done into the current song index, a play/pause level and a player-restart pulse. Parametrised successor of the fixed four-song controller. Adds configurable playlist length, a previous-song button and four loop modes (advance-and-pause, continuous, repeat-one, repeat-all). Sits between the button one-pulsers and the song_reader/note_player datapath.

## Interface
- NUM_SONGS, 4, number of songs in ROM; 2 ≤ NUM_SONGS ≤ 2^SONG_W
- SONG_W, 2, width of song index

- clk  input  1  system clock; one clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- play_button  input  1  one-cycle pulse; toggles play/pause
- next_button  input  1  one-cycle pulse; advance to next song
- prev_button  input  1  one-cycle pulse; go to previous song
- song_done  input  1  one-cycle pulse from player at end of current song
- loop_mode  input  2  00 ADV_PAUSE, 01 CONTINUOUS, 10 REPEAT_ONE, 11 REPEAT_ALL; sampled only when song_done acts
- play  output  1  1 = player runs, 0 = paused
- reset_player  output  1  one-cycle pulse; player restarts current song from its first note
- song  output  SONG_W  current song index, 0..NUM_SONGS-1

## Operation
- All outputs registered. Two-state FSM on play: PAUSED (play=0), PLAYING (play=1). Separate song register; reset_player register.
- Reset (while reset=1): song=0, play=0 (PAUSED), reset_player=1.
- Per-cycle event priority: song_done > next_button > prev_button > play_button. Only the highest-priority asserted event acts; the others are dropped.
- song_done honoured only in PLAYING; ignored in PAUSED. Let last = NUM_SONGS-1.
  - ADV_PAUSE: song = (song==last) ? 0 : song+1; go PAUSED.
  - CONTINUOUS: if song≠last: song+1, stay PLAYING; if song==last: song=0, go PAUSED.
  - REPEAT_ONE: song unchanged, stay PLAYING.
  - REPEAT_ALL: song = (song==last) ? 0 : song+1, stay PLAYING.
- next_button: song = (song==last) ? 0 : song+1; go PAUSED (either state).
- prev_button: song = (song==0) ? last : song-1; go PAUSED (either state).
- play_button: PAUSED→PLAYING, PLAYING→PAUSED; song unchanged; no reset_player.
- reset_player = 1 for exactly one cycle after any acted song_done, next_button or prev_button, including REPEAT_ONE and wraps where the index is unchanged numerically.
- Index arithmetic is modulo NUM_SONGS via explicit compare to last, not natural SONG_W overflow. Values ≥ NUM_SONGS are never produced.

## Timing
- Event sampled at rising edge N; song, play and reset_player take new values after edge N, visible in cycle N+1. Latency: 1 cycle.
- reset_player high in cycle N+1 only. Cleared at edge N+1 unless another song-changing event is sampled there.
- Reset release: reset sampled low at edge R; reset_player=0 from cycle R+1. Inputs sampled at edge R are already acted on.
- Reset mid-song or mid-pulse: reset wins over all events. Same edge returns song=0, play=0, reset_player=1.
- Back-to-back events on consecutive edges each act. No input is buffered.

## Test plan
- Reset, NUM_SONGS=4: during reset song=0, play=0, reset_player=1. One cycle after release reset_player=0. play_button pulse → play=1 next cycle, song=0, reset_player stays 0.
- ADV_PAUSE sweep: PLAYING song 3, song_done → song=0, play=0, reset_player pulse 1 cycle. From song 1 playing, next_button → song=2, play=0.
- prev wrap and priority: song=0, prev_button → song=3, play=0. Same-cycle song_done+next_button while PLAYING song 1 in ADV_PAUSE → song=2 (single advance), play=0. song_done while PAUSED → no change, no pulse.
- Modes: CONTINUOUS song 2 done → song=3, play=1. Song 3 done → song=0, play=0. REPEAT_ONE song 1 done → song=1, play=1, reset_player pulse. REPEAT_ALL song 3 done → song=0, play=1.
- Non-power-of-two: NUM_SONGS=5, SONG_W=3. next from 4 → 0. prev from 0 → 4. song never reaches 5–7 across 20 random button/done pulses.
- Mid-operation reset: PLAYING song 2, assert reset with simultaneous next_button → next cycle song=0, play=0, reset_player=1.

Source files
------------

// File: rtl/playlist_mcu.sv
// Playback control unit: turns one-cycle button pulses and the player's
// song_done into the current song index, a play/pause level and a one-cycle
// player-restart pulse. Playlist length and index width are parameters.
module playlist_mcu #(
  parameter int unsigned NUM_SONGS = 4,
  parameter int unsigned SONG_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_button,
  input  logic              next_button,
  input  logic              prev_button,
  input  logic              song_done,
  input  logic [1:0]        loop_mode,
  output logic              play,
  output logic              reset_player,
  output logic [SONG_W-1:0] song
);

  typedef enum logic [0:0] {StPaused, StPlaying} state_e;

  localparam logic [1:0] ModeAdvPause   = 2'b00;
  localparam logic [1:0] ModeContinuous = 2'b01;
  localparam logic [1:0] ModeRepeatOne  = 2'b10;
  localparam logic [1:0] ModeRepeatAll  = 2'b11;

  localparam logic [SONG_W-1:0] Last = SONG_W'(NUM_SONGS - 1);
  localparam logic [SONG_W-1:0] One  = SONG_W'(1);

  state_e            state_q, state_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic              reset_player_q, reset_player_d;
  logic [SONG_W-1:0] song_next, song_prev;

  // Wrap explicitly at the playlist end so non-power-of-two lengths never
  // produce an out-of-range index.
  always_comb begin
    song_next = (song_q == Last) ? '0 : song_q + One;
    song_prev = (song_q == '0) ? Last : song_q - One;
  end

  // Next-state: one event per cycle, song_done > next > prev > play.
  always_comb begin
    state_d        = state_q;
    song_d         = song_q;
    reset_player_d = 1'b0;
    if (song_done && (state_q == StPlaying)) begin
      reset_player_d = 1'b1;
      unique case (loop_mode)
        ModeAdvPause: begin
          song_d  = song_next;
          state_d = StPaused;
        end
        ModeContinuous: begin
          song_d  = song_next;
          state_d = (song_q == Last) ? StPaused : StPlaying;
        end
        ModeRepeatOne: begin
          song_d  = song_q;
          state_d = StPlaying;
        end
        ModeRepeatAll: begin
          song_d  = song_next;
          state_d = StPlaying;
        end
        default: ;
      endcase
    end else if (next_button) begin
      song_d         = song_next;
      state_d        = StPaused;
      reset_player_d = 1'b1;
    end else if (prev_button) begin
      song_d         = song_prev;
      state_d        = StPaused;
      reset_player_d = 1'b1;
    end else if (play_button) begin
      state_d = (state_q == StPlaying) ? StPaused : StPlaying;
    end
  end

  // State, song and restart-pulse registers; reset holds the player restarted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StPaused;
      song_q         <= '0;
      reset_player_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      song_q         <= song_d;
      reset_player_q <= reset_player_d;
    end
  end

  assign play         = (state_q == StPlaying);
  assign reset_player = reset_player_q;
  assign song         = song_q;

endmodule

// File: tb/tb_playlist_mcu.sv
// Scoreboard bench for playlist_mcu: a 4-song instance and a 5-song instance.
// Stimulus pushes expected outputs tagged with the cycle they are due; a
// separate monitor pops and compares them on the falling edge.
module tb_playlist_mcu;

  logic       clk = 1'b0;
  logic [1:0] rst = 2'b11;
  logic [1:0] pb  = '0;
  logic [1:0] nb  = '0;
  logic [1:0] pv  = '0;
  logic [1:0] sd  = '0;
  logic [1:0] lm0 = '0;
  logic [1:0] lm1 = '0;

  logic       play4, rp4, play5, rp5;
  logic [1:0] song4;
  logic [2:0] song5;

  always #5 clk = ~clk;

  playlist_mcu #(.NUM_SONGS(4), .SONG_W(2)) dut4 (
    .clk(clk), .reset(rst[0]), .play_button(pb[0]), .next_button(nb[0]),
    .prev_button(pv[0]), .song_done(sd[0]), .loop_mode(lm0),
    .play(play4), .reset_player(rp4), .song(song4)
  );

  playlist_mcu #(.NUM_SONGS(5), .SONG_W(3)) dut5 (
    .clk(clk), .reset(rst[1]), .play_button(pb[1]), .next_button(nb[1]),
    .prev_button(pv[1]), .song_done(sd[1]), .loop_mode(lm1),
    .play(play5), .reset_player(rp5), .song(song5)
  );

  typedef struct {
    int    due;
    bit    inst;
    bit    rng;
    int    song;
    bit    play;
    bit    rp;
    string nm;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   passes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation whose due cycle has arrived.
  always @(negedge clk) begin
    exp_t e;
    int   as;
    bit   ap, arp;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e   = sb.pop_front();
      as  = e.inst ? int'(song5) : int'(song4);
      ap  = e.inst ? play5 : play4;
      arp = e.inst ? rp5 : rp4;
      if (e.rng) begin
        checks++;
        if (as < 5) passes++;
        else $display("FAIL %s range: song=%0d required <5", e.nm, as);
      end else begin
        checks++;
        if (as == e.song) passes++;
        else $display("FAIL %s song: got %0d required %0d", e.nm, as, e.song);
        checks++;
        if (ap == e.play) passes++;
        else $display("FAIL %s play: got %0d required %0d", e.nm, ap, e.play);
        checks++;
        if (arp == e.rp) passes++;
        else $display("FAIL %s reset_player: got %0d required %0d", e.nm, arp, e.rp);
      end
    end
  end

  // Drive one cycle of inputs on one instance and queue the expected result.
  task automatic step(input bit inst, input bit r, input bit p, input bit n, input bit v,
                      input bit d, input logic [1:0] m, input int es, input bit ep,
                      input bit erp, input string nm, input bit rng = 1'b0);
    exp_t e;
    @(posedge clk);
    #1;
    rst[inst] = r;
    pb[inst]  = p;
    nb[inst]  = n;
    pv[inst]  = v;
    sd[inst]  = d;
    if (inst) lm1 = m;
    else lm0 = m;
    e.due  = cyc + 1;
    e.inst = inst;
    e.rng  = rng;
    e.song = es;
    e.play = ep;
    e.rp   = erp;
    e.nm   = nm;
    sb.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //          inst rst pb nb pv sd mode   song play rp  name
    step(1'b0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 1, "reset_a");
    step(1'b0, 1, 1, 1, 0, 0, 2'd0, 0, 0, 1, "reset_b");
    step(1'b0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, "release");
    step(1'b0, 0, 1, 0, 0, 0, 2'd0, 0, 1, 0, "play_on");
    step(1'b0, 0, 0, 1, 0, 0, 2'd0, 1, 0, 1, "next_from_0");
    step(1'b0, 0, 1, 0, 0, 0, 2'd0, 1, 1, 0, "play_song1");
    step(1'b0, 0, 0, 1, 0, 0, 2'd0, 2, 0, 1, "next_from_1");
    step(1'b0, 0, 0, 1, 0, 0, 2'd0, 3, 0, 1, "next_from_2");
    step(1'b0, 0, 1, 0, 0, 0, 2'd0, 3, 1, 0, "play_song3");
    step(1'b0, 0, 0, 0, 0, 1, 2'd0, 0, 0, 1, "adv_pause_wrap");
    step(1'b0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, "pulse_one_cycle");
    step(1'b0, 0, 0, 0, 1, 0, 2'd0, 3, 0, 1, "prev_wrap");
    step(1'b0, 0, 0, 0, 1, 0, 2'd0, 2, 0, 1, "prev_3");
    step(1'b0, 0, 0, 0, 1, 0, 2'd0, 1, 0, 1, "prev_2");
    step(1'b0, 0, 1, 0, 0, 0, 2'd0, 1, 1, 0, "play_again");
    step(1'b0, 0, 0, 1, 0, 1, 2'd0, 2, 0, 1, "done_over_next");
    step(1'b0, 0, 0, 0, 0, 1, 2'd0, 2, 0, 0, "done_paused");
    step(1'b0, 0, 1, 0, 0, 0, 2'd1, 2, 1, 0, "play_song2");
    step(1'b0, 0, 0, 0, 0, 1, 2'd1, 3, 1, 1, "continuous");
    step(1'b0, 0, 0, 0, 0, 1, 2'd1, 0, 0, 1, "continuous_end");
    step(1'b0, 0, 1, 1, 0, 0, 2'd1, 1, 0, 1, "next_over_play");
    step(1'b0, 0, 1, 0, 0, 0, 2'd2, 1, 1, 0, "play_rpt1");
    step(1'b0, 0, 0, 0, 0, 1, 2'd2, 1, 1, 1, "repeat_one");
    step(1'b0, 0, 0, 0, 0, 0, 2'd2, 1, 1, 0, "repeat_one_idle");
    step(1'b0, 0, 0, 1, 0, 0, 2'd3, 2, 0, 1, "next_to_2");
    step(1'b0, 0, 0, 1, 0, 0, 2'd3, 3, 0, 1, "next_to_3");
    step(1'b0, 0, 1, 0, 0, 0, 2'd3, 3, 1, 0, "play_rptall");
    step(1'b0, 0, 0, 0, 0, 1, 2'd3, 0, 1, 1, "repeat_all_wrap");
    step(1'b0, 0, 0, 0, 0, 1, 2'd3, 1, 1, 1, "repeat_all_0");
    step(1'b0, 0, 0, 0, 0, 1, 2'd3, 2, 1, 1, "repeat_all_1");
    step(1'b0, 1, 0, 1, 0, 0, 2'd3, 0, 0, 1, "mid_reset");
    step(1'b0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, "mid_release");
    step(1'b0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, "idle4");

    step(1'b1, 1, 0, 0, 0, 0, 2'd0, 0, 0, 1, "n5_reset");
    step(1'b1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, "n5_release");
    step(1'b1, 0, 0, 0, 1, 0, 2'd0, 4, 0, 1, "n5_prev_wrap");
    step(1'b1, 0, 0, 1, 0, 0, 2'd0, 0, 0, 1, "n5_next_wrap");
    step(1'b1, 0, 0, 0, 1, 0, 2'd0, 4, 0, 1, "n5_prev_4");
    step(1'b1, 0, 1, 0, 0, 0, 2'd3, 4, 1, 0, "n5_play");
    step(1'b1, 0, 0, 0, 0, 1, 2'd3, 0, 1, 1, "n5_rpt_all_wrap");
    for (int i = 0; i < 20; i++) begin
      int unsigned k;
      logic [1:0]  m;
      k = $urandom_range(0, 3);
      m = 2'($urandom_range(0, 3));
      step(1'b1, 0, k == 0, k == 1, k == 2, k == 3, m, 0, 0, 0, "n5_random", 1'b1);
    end
    @(posedge clk);
    #1;
    pb = '0; nb = '0; pv = '0; sd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: %0d pending required 0", sb.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
